load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Pipeline-side initiator for the data memory port; sits between the MEM stage and data_memory.
- Accepts one load/store request at a time and drives the memory interface.
- Aligned accesses take 1 memory beat. Misaligned halfword/word accesses are split into sequential byte beats.
- Assembles and extends load data, then returns a one-cycle completion pulse. The pipeline stalls on `req_ready=0`.

Parameters:
- SPLIT_MISALIGNED, 1, 1 = split misaligned accesses into byte beats; 0 = complete them with `resp_error`, no memory access.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  load extension: 0 = sign-extend, 1 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  qualified by `resp_valid`
- resp_split  out  1  qualified by `resp_valid`; access was split into byte beats
- mem_address  out  32  memory byte address
- mem_write_data  out  32  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_size  out  2  memory access size
- mem_unsigned  out  1  memory zero-extend select
- mem_read_data  in  32  asynchronous memory read data

Behaviour:
- States: IDLE, BEAT, RESP.
- Reset (asynchronous) forces IDLE and zeroes beat count, accumulator and all response outputs. `mem_read`/`mem_write` deassert immediately, so a reset in the middle of a split access abandons the remaining beats.
- `req_ready` = 1 only in IDLE. A request is accepted on `req_valid && req_ready`; all `req_*` fields are captured into registers.
- Alignment:
  - Byte: always aligned.
  - Halfword: aligned when `addr[0]=0`.
  - Word: aligned when `addr[1:0]=0`.
- Beat count N:
  - Aligned access: N=1.
  - Misaligned access with SPLIT_MISALIGNED=1: N = 2 (halfword) or 4 (word).
  - `size=11`, or misaligned with SPLIT_MISALIGNED=0: N=0.
- Transitions:
  - IDLE → BEAT on accept when N>0.
  - IDLE → RESP on accept when N=0.
  - BEAT → RESP after beat N-1.
  - RESP → IDLE unconditionally.
  - No acceptance occurs during RESP, so back-to-back requests cost 1 bubble.
- Memory outputs are combinational from the registered state. They are all zero outside BEAT.
- Aligned beat:
  - `mem_address` = addr, `mem_size` = size, `mem_unsigned` = req_unsigned, `mem_write_data` = wdata.
  - Strobe: `mem_write` = write, `mem_read` = !write.
- Split beat k (k = 0..N-1):
  - `mem_address` = addr+k, modulo 2^32 (wraps past 0xFFFFFFFF).
  - `mem_size` = 00, `mem_unsigned` = 1, `mem_write_data` = {24'b0, wdata[8k+7:8k]}.
- Loads:
  - `mem_read_data` is sampled at the end of each BEAT cycle.
  - Split beat k stores `mem_read_data[7:0]` into accumulator byte k (little-endian).
  - Aligned beats store `mem_read_data` whole.
- Split load result: on entry to RESP, the accumulator is sign- or zero-extended from bit 15 (halfword) or passed through (word).
- Latency: accept at edge T → beats in cycles T+1..T+N → `resp_valid` high in cycle T+N+1 only.
- In the RESP cycle:
  - `resp_rdata` = the result for loads, 0 for stores and errors.
  - `resp_error` = 1 when N=0.
  - `resp_split` = 1 when N>1.
- Response outputs return to 0 in IDLE.
- Store beats write memory on the rising edge that ends the beat. A split store is never partially repeated.

Decomposition:
- Shared package lsu_pkg:
  - SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10.
  - State encodings IDLE/BEAT/RESP.
  - Function returning beat count from size, `addr[1:0]` and SPLIT_MISALIGNED.
- One sub-module: lsu_extend — combinational sign/zero extension of an assembled value given size and the unsigned flag. Also used by the aligned path for consistency.

Test Plan:
- Aligned word store 0xDEADBEEF at 0x100, then word load 0x100 → 1 beat each; `resp_valid` 2 cycles after accept; load `resp_rdata`=0xDEADBEEF; `resp_split`=0.
- Halfword store 0x8001 at 0x202, then signed halfword load → `resp_rdata`=0xFFFF8001. Unsigned halfword load → 0x00008001.
- Misaligned word store 0x11223344 at 0x301 → 4 byte beats at 0x301..0x304 with data 44,33,22,11. Word load 0x301 → 0x11223344; `resp_split`=1; `resp_valid` at T+5.
- Misaligned signed halfword load at 0x103 over bytes 0x80 (0x103), 0xFF (0x104) → `resp_rdata`=0xFFFFFF80. Address wrap: halfword access at 0xFFFFFFFF → beats at 0xFFFFFFFF, 0x00000000.
- `size=11` request; and misaligned word at 0x2 with SPLIT_MISALIGNED=0 → no `mem_read`/`mem_write` strobes; `resp_error`=1 at T+1; `resp_rdata`=0.
- Reset asserted during beat 2 of a split store → `mem_write` drops immediately; bytes 2..3 unwritten; `req_ready`=1 after reset release; next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    RESP = 2'd2
  } state_t;

  // 0 beats means the request completes with an error
  function automatic logic [2:0] beat_count(
    input logic [1:0] size,
    input logic [1:0] lo,
    input logic       split
  );
    logic [2:0] n;
    case (size)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = !lo[0] ? 3'd1 :
                     (split ? 3'd2 : 3'd0);
      SIZE_WORD: n = (lo == 2'b00) ? 3'd1 :
                     (split ? 3'd4 : 3'd0);
      default:   n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of an assembled load value.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] value,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic sb, sh;

  always_comb begin
    sb = ~is_unsigned & value[7];
    sh = ~is_unsigned & value[15];
    case (size)
      SIZE_BYTE: result = {{24{sb}}, value[7:0]};
      SIZE_HALF: result = {{16{sh}}, value[15:0]};
      default:   result = value;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Pipeline-side data memory initiator; splits
// misaligned accesses into byte beats.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        resp_split,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  input  logic [31:0] mem_read_data
);

  state_t      state;
  logic        wr;
  logic        uns;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] acc;
  logic [31:0] acc_next;
  logic [31:0] ext;
  logic [2:0]  n;
  logic [2:0]  k;
  logic [2:0]  n_new;
  logic [4:0]  sh;
  logic        split;
  logic        accept;
  logic        last;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign split     = (n != 3'd1);
  assign sh        = {k[1:0], 3'b000};
  assign last      = (k == n - 3'd1);
  assign n_new     = beat_count(req_size, req_addr[1:0],
                                SPLIT_MISALIGNED != 0);

  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_size       = 2'b00;
    mem_unsigned   = 1'b0;
    if (state == BEAT) begin
      mem_read  = !wr;
      mem_write = wr;
      if (split) begin
        mem_address    = addr + {29'b0, k};
        mem_size       = SIZE_BYTE;
        mem_unsigned   = 1'b1;
        mem_write_data = {24'b0, wdata[sh +: 8]};
      end else begin
        mem_address    = addr;
        mem_size       = size;
        mem_unsigned   = uns;
        mem_write_data = wdata;
      end
    end
  end

  // split beats fill the accumulator little-endian
  always_comb begin
    acc_next = acc;
    if (split) acc_next[sh +: 8] = mem_read_data[7:0];
    else       acc_next = mem_read_data;
  end

  lsu_extend u_extend (
    .value       (acc_next),
    .size        (size),
    .is_unsigned (uns),
    .result      (ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr         <= 1'b0;
      uns        <= 1'b0;
      size       <= 2'b00;
      addr       <= '0;
      wdata      <= '0;
      acc        <= '0;
      n          <= '0;
      k          <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      resp_split <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          wr    <= req_write;
          uns   <= req_unsigned;
          size  <= req_size;
          addr  <= req_addr;
          wdata <= req_wdata;
          acc   <= '0;
          k     <= '0;
          n     <= n_new;
          if (n_new == 3'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
          end else begin
            state <= BEAT;
          end
        end
        BEAT: begin
          acc <= acc_next;
          if (last) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= wr ? 32'h0 : ext;
            resp_split <= split;
          end else begin
            k <= k + 3'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_error <= 1'b0;
          resp_split <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
